// File: rtl/rom_boot_pkg.sv
// rom_boot_pkg: shared constants and state encoding for the ROM bootloader
package rom_boot_pkg;
    localparam int SRAM_AW    = 19;
    localparam int WORD_BYTES = 4;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        ACK      = 3'd2,
        WAIT_LOW = 3'd3,
        DONE     = 3'd4
    } state_t;
endpackage

// File: rtl/rom_bootloader_word_unpacker.sv
// word_unpacker: holds one 32-bit host word and presents it MSB-first, one byte per advance
module word_unpacker
    import rom_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] word,
    output logic [7:0]  byte_out,
    output logic        last
);
    logic [31:0] shreg;
    logic [1:0]  idx;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            idx   <= '0;
        end else if (load) begin
            shreg <= word;
            idx   <= '0;
        end else if (advance) begin
            shreg <= {shreg[23:0], 8'h00};
            idx   <= idx + 2'd1;
        end
    end
    assign byte_out = shreg[31:24];
    assign last     = idx == 2'(WORD_BYTES - 1);
endmodule

// File: rtl/rom_bootloader.sv
// rom_bootloader: streams host ROM words into SRAM one byte at a time, then flags initialised.
// Define ROM_BOOTLOADER_CHECKSUM_EN to accumulate a 16-bit sum of written bytes on rom_checksum.
module rom_bootloader
    import rom_boot_pkg::*;
#(
    parameter logic [SRAM_AW-1:0] BASE_ADDR = 19'h00000,
    parameter int                 ROM_BYTES = 49152
) (
    input  logic               ck16,
    input  logic               pown_reset_n,
    input  logic [31:0]        host_bootdata,
    input  logic               host_bootdata_req,
    output logic               host_bootdata_ack,
    output logic [SRAM_AW-1:0] romwrite_addr,
    output logic [7:0]         romwrite_data,
    output logic               romwrite_wr,
    input  logic               romwrite_ready,
    output logic               host_rom_initialised,
    output logic [15:0]        rom_checksum
);
    localparam int CW = SRAM_AW + 1;
    state_t        state, next_state;
    logic [CW-1:0] count;
    logic [7:0]    cur_byte;
    logic          last, load, advance;
    assign load    = state == IDLE && host_bootdata_req;
    assign advance = state == WRITE && romwrite_ready;
    word_unpacker u_unpack (
        .clk      (ck16),
        .rst_n    (pown_reset_n),
        .load     (load),
        .advance  (advance),
        .word     (host_bootdata),
        .byte_out (cur_byte),
        .last     (last)
    );
    always_ff @(posedge ck16) begin
        if (!pown_reset_n) state <= IDLE;
        else               state <= next_state;
    end
    // WAIT_LOW keeps a held req from being captured a second time
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     next_state = host_bootdata_req ? WRITE : IDLE;
            WRITE:    next_state = advance && last ? ACK : WRITE;
            ACK:      next_state = count == CW'(ROM_BYTES) ? DONE : WAIT_LOW;
            WAIT_LOW: next_state = host_bootdata_req ? WAIT_LOW : IDLE;
            DONE:     next_state = DONE;
            default:  next_state = IDLE;
        endcase
    end
    always_comb begin
        romwrite_wr          = state == WRITE;
        romwrite_data        = state == WRITE ? cur_byte : 8'h00;
        romwrite_addr        = BASE_ADDR + count[SRAM_AW-1:0];
        host_bootdata_ack    = state == ACK;
        host_rom_initialised = state == DONE;
    end
    always_ff @(posedge ck16) begin
        if (!pown_reset_n) count <= '0;
        else if (advance)  count <= count + CW'(1);
    end
`ifdef ROM_BOOTLOADER_CHECKSUM_EN
    always_ff @(posedge ck16) begin
        if (!pown_reset_n) rom_checksum <= '0;
        else if (advance)  rom_checksum <= rom_checksum + {8'h00, cur_byte};
    end
`else
    assign rom_checksum = 16'h0000;
`endif
    always_ff @(posedge ck16) begin
        assert (32'(BASE_ADDR) + 32'(ROM_BYTES) <= 32'(2 ** SRAM_AW) && ROM_BYTES % WORD_BYTES == 0 && ROM_BYTES > 0)
            else $error("rom_bootloader: BASE_ADDR/ROM_BYTES exceed the SRAM or are not whole words");
    end
endmodule

// File: tb/tb_rom_bootloader.sv
// tb_rom_bootloader: directed bench with a byte-queue model checked every cycle on three configurations
module tb_rom_bootloader;
`ifdef ROM_BOOTLOADER_CHECKSUM_EN
    localparam bit CSUM = 1;
`else
    localparam bit CSUM = 0;
`endif
    logic        ck16 = 0;
    logic        rst_n = 0;
    logic [31:0] bootdata = 0;
    logic        ready = 1;
    logic        req [3];
    logic        ack [3], wr [3], init [3];
    logic [18:0] addr [3];
    logic [7:0]  data [3];
    logic [15:0] csum [3];

    logic [18:0] base_a [3] = '{19'h00000, 19'h00000, 19'h7FFFC};
    int          rom_b [3] = '{49152, 8, 4};
    logic [26:0] expm [3][16];
    int          wp [3] = '{0, 0, 0};
    int          rp [3] = '{0, 0, 0};
    int          pushed [3] = '{0, 0, 0};
    int          accepted [3] = '{0, 0, 0};
    logic [15:0] msum [3] = '{16'h0, 16'h0, 16'h0};
    bit          inflight [3] = '{0, 0, 0};
    bit          mdone [3] = '{0, 0, 0};
    int          n_chk = 0;
    int          n_fail = 0;
    int          n;

    always #5 ck16 = ~ck16;

    rom_bootloader u0 (
        .ck16(ck16), .pown_reset_n(rst_n), .host_bootdata(bootdata), .host_bootdata_req(req[0]),
        .host_bootdata_ack(ack[0]), .romwrite_addr(addr[0]), .romwrite_data(data[0]), .romwrite_wr(wr[0]),
        .romwrite_ready(ready), .host_rom_initialised(init[0]), .rom_checksum(csum[0])
    );
    rom_bootloader #(.BASE_ADDR(19'h00000), .ROM_BYTES(8)) u1 (
        .ck16(ck16), .pown_reset_n(rst_n), .host_bootdata(bootdata), .host_bootdata_req(req[1]),
        .host_bootdata_ack(ack[1]), .romwrite_addr(addr[1]), .romwrite_data(data[1]), .romwrite_wr(wr[1]),
        .romwrite_ready(ready), .host_rom_initialised(init[1]), .rom_checksum(csum[1])
    );
    rom_bootloader #(.BASE_ADDR(19'h7FFFC), .ROM_BYTES(4)) u2 (
        .ck16(ck16), .pown_reset_n(rst_n), .host_bootdata(bootdata), .host_bootdata_req(req[2]),
        .host_bootdata_ack(ack[2]), .romwrite_addr(addr[2]), .romwrite_data(data[2]), .romwrite_wr(wr[2]),
        .romwrite_ready(ready), .host_rom_initialised(init[2]), .rom_checksum(csum[2])
    );

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    task automatic push_word(int i, logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            expm[i][wp[i] % 16] = {base_a[i] + 19'(pushed[i]), w[31-8*b -: 8]};
            wp[i]++;
            pushed[i]++;
        end
        inflight[i] = 1;
    endtask

    // Model: every host word becomes four queued (addr, byte) writes; acceptance pops them
    always @(negedge ck16) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("init%0d", i), 32'(init[i]), 32'(mdone[i]));
            chk($sformatf("csum%0d", i), 32'(csum[i]), CSUM ? 32'(msum[i]) : 32'h0);
            if (wr[i]) begin
                if (wp[i] == rp[i]) chk($sformatf("wr_unexpected%0d", i), 32'(wr[i]), 32'h0);
                else begin
                    chk($sformatf("write%0d", i), 32'({addr[i], data[i]}), 32'(expm[i][rp[i] % 16]));
                    if (ready && rst_n) begin
                        msum[i] = msum[i] + 16'(data[i]);
                        accepted[i]++;
                        rp[i]++;
                    end
                end
            end
            if (ack[i]) begin
                chk($sformatf("ack_unexpected%0d", i), 32'(ack[i]), 32'(inflight[i] && wp[i] == rp[i]));
                inflight[i] = 0;
                if (accepted[i] == rom_b[i]) mdone[i] = 1;
            end
            if (!rst_n) begin
                wp[i] = 0; rp[i] = 0; pushed[i] = 0; accepted[i] = 0;
                msum[i] = 0; inflight[i] = 0; mdone[i] = 0;
            end
        end
    end

    task automatic step();
        @(posedge ck16);
        #2;
    endtask

    task automatic word_lit(int i, logic [31:0] w, logic [18:0] a0);
        bootdata = w;
        req[i] = 1;
        push_word(i, w);
        for (int b = 0; b < 4; b++) begin
            step();
            chk("lit_wr", 32'(wr[i]), 32'h1);
            chk("lit_addr", 32'(addr[i]), 32'(a0 + 19'(b)));
            chk("lit_data", 32'(data[i]), 32'(w[31-8*b -: 8]));
        end
        step();
        chk("lit_ack", 32'(ack[i]), 32'h1);
        chk("lit_wr_off", 32'(wr[i]), 32'h0);
        req[i] = 0;
        step();
        chk("lit_ack_pulse", 32'(ack[i]), 32'h0);
        step();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) req[i] = 0;
        step();
        step();
        chk("rst_wr", 32'(wr[0]), 32'h0);
        chk("rst_ack", 32'(ack[0]), 32'h0);
        chk("rst_addr", 32'(addr[0]), 32'h0);
        chk("rst_data", 32'(data[0]), 32'h0);
        chk("rst_init", 32'(init[0]), 32'h0);
        chk("rst_csum", 32'(csum[0]), 32'h0);
        chk("rst_addr_top", 32'(addr[2]), 32'h7FFFC);
        rst_n = 1;
        step();
        word_lit(0, 32'hDEADBEEF, 19'h0);
        chk("one_word_init", 32'(init[0]), 32'h0);
        // ready stall on byte 2, then req held high across the ack
        rst_n = 0;
        step();
        rst_n = 1;
        bootdata = 32'hDEADBEEF;
        req[0] = 1;
        push_word(0, bootdata);
        step(); step(); step();
        n = 3;
        chk("stall_addr", 32'(addr[0]), 32'h2);
        ready = 0;
        repeat (3) begin
            step();
            n++;
            chk("stall_wr", 32'(wr[0]), 32'h1);
            chk("stall_addr_hold", 32'(addr[0]), 32'h2);
            chk("stall_data_hold", 32'(data[0]), 32'hBE);
        end
        ready = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            n++;
            if (ack[0]) break;
        end
        chk("stall_ack_latency", 32'(n), 32'd8);
        repeat (10) begin
            step();
            chk("held_req_wr", 32'(wr[0]), 32'h0);
            chk("held_req_ack", 32'(ack[0]), 32'h0);
        end
        req[0] = 0;
        step();
        word_lit(0, 32'hCAFEF00D, 19'h4);
        // reset two bytes into a word with req still high
        bootdata = 32'h12345678;
        req[0] = 1;
        push_word(0, bootdata);
        step(); step(); step();
        chk("midrst_pre_addr", 32'(addr[0]), 32'hA);
        rst_n = 0;
        step();
        chk("midrst_wr", 32'(wr[0]), 32'h0);
        chk("midrst_addr", 32'(addr[0]), 32'h0);
        rst_n = 1;
        word_lit(0, 32'hDEADBEEF, 19'h0);
        // full load on the 8-byte configuration
        word_lit(1, 32'h01020304, 19'h0);
        chk("full_init_early", 32'(init[1]), 32'h0);
        word_lit(1, 32'h05060708, 19'h4);
        chk("full_init", 32'(init[1]), 32'h1);
        chk("full_csum", 32'(csum[1]), CSUM ? 32'h24 : 32'h0);
        bootdata = 32'hFFFFFFFF;
        req[1] = 1;
        repeat (10) begin
            step();
            chk("done_wr", 32'(wr[1]), 32'h0);
            chk("done_ack", 32'(ack[1]), 32'h0);
        end
        req[1] = 0;
        chk("done_csum_frozen", 32'(csum[1]), CSUM ? 32'h24 : 32'h0);
        // top-of-SRAM configuration
        word_lit(2, 32'hA1B2C3D4, 19'h7FFFC);
        chk("top_init", 32'(init[2]), 32'h1);
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
